counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Sequencing controller for the 16-bit free-running counter datapath. It wraps an increment-by-one counter register with a start/hold/clear command interface, a programmable terminal limit, and one-shot or auto-reload operation, and it reports progress through busy, done and wrap status. It sits between a host or top-level FSM and the counter datapath. It replaces the bare "count or synchronously clear" register with a managed, restartable count sequence.

## Interface
- `WIDTH`, default 16: counter and limit width in bits.
- `i_clk` input 1: single clock; all state changes on the rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: start or restart a count sequence; level-sampled.
- `i_hold` input 1: pause counting while high.
- `i_clear` input 1: synchronous abort to IDLE.
- `i_mode` input 1: 0 = one-shot, 1 = auto-reload; sampled with `i_start`.
- `i_limit` input WIDTH: terminal count; sampled with `i_start`.
- `i_div` input 8: prescale divisor; present only with `COUNTER_CTRL_PRESCALE_EN`.
- `o_count` output WIDTH: current count.
- `o_busy` output 1: high in RUN and HOLD.
- `o_done` output 1: one-cycle pulse on the one-shot terminal.
- `o_wrap` output 1: one-cycle pulse on an auto-reload wrap.

## Operation
- States:
  - IDLE: reset state, count held.
  - RUN: counting.
  - HOLD: paused, count frozen.
  - DONE: one-shot finished, count held at the limit.
- Reset (`i_rst_n`=0, asynchronous): state IDLE, `o_count`=0, `o_busy`=0, `o_done`=0, `o_wrap`=0, latched limit and mode = 0.
- Command priority per edge: `i_clear` > `i_start` > `i_hold`.
- `i_clear`: from any state → IDLE, `o_count`=0, no done or wrap pulse.
- `i_start` in any state except when `i_clear` is high:
  - latch `i_limit` and `i_mode`;
  - `o_count`←0;
  - → RUN.
  - Restart mid-run is legal and aborts the current sequence without a done or wrap pulse.
- RUN:
  - if `i_hold`: → HOLD, no increment;
  - else if `o_count`==limit:
    - one-shot: → DONE, count holds, `o_done` pulses;
    - auto-reload: `o_count`←0, `o_wrap` pulses, stay in RUN;
  - else `o_count`←`o_count`+1.
- HOLD: if `!i_hold` → RUN, no increment on that edge. Incrementing resumes on the following edge.
- DONE: holds until `i_start` or `i_clear`.
- Arithmetic: unsigned, WIDTH bits. A limit of 2^WIDTH−1 is legal; the counter never passes the limit, so it cannot overflow.
- Limit 0:
  - one-shot reaches DONE on the first RUN edge;
  - auto-reload pulses `o_wrap` every cycle.
- `o_done` and `o_wrap` are registered. Each is high for exactly one cycle, after the edge that performs the terminal action.

## Timing
- `i_start` sampled at edge k: after edge k, `o_count`=0 and `o_busy`=1.
- With no hold, after edge k+n, `o_count`=n, for n ≤ limit.
- One-shot: after edge k+limit+1, state is DONE, `o_busy`=0, and `o_done`=1 for that cycle only.
- Auto-reload period is limit+1 cycles. `o_wrap` is high during the cycle in which `o_count` has just returned to 0.
- Each hold cycle extends the sequence by one cycle. Each hold entry or exit edge adds one further non-counting edge.
- Reset asserted mid-sequence clears all state immediately, without waiting for a clock edge. Release is synchronous to the next edge, with the controller in IDLE.

## Configuration
- `COUNTER_CTRL_PRESCALE_EN` defined:
  - adds port `i_div` and an 8-bit prescaler;
  - in RUN, the increment or terminal action occurs only on a tick, and a tick happens when the prescaler equals `i_div`, after which the prescaler returns to 0;
  - the prescaler is reset to 0 by reset, `i_start` and `i_clear`, and is frozen in HOLD;
  - `i_div`=0 behaves identically to the undefined case;
  - hold is still sampled every cycle.
- Undefined: no `i_div` port, and the count advances every RUN cycle.

## Test plan
- Reset release, no commands for 10 cycles → `o_count`=0, `o_busy`=0, no pulses.
- One-shot: `i_start` with `i_limit`=5, `i_mode`=0 → `o_count` reads 0,1,2,3,4,5 on consecutive cycles, then DONE with `o_done` high for 1 cycle and `o_count` held at 5.
- Auto-reload: `i_limit`=3, `i_mode`=1 → `o_count` sequence 0,1,2,3,0,1,… with `o_wrap` high whenever 0 follows 3; `o_done` never asserts.
- Hold and clear:
  - `i_hold` high for 4 cycles at `o_count`=2 → count frozen at 2, completion delayed by 5 cycles;
  - `i_clear` asserted together with `i_start` → IDLE, `o_count`=0.
- Async reset: drop `i_rst_n` mid-cycle at `o_count`=7 → outputs go to 0 before the next edge; `i_start` with `i_limit`=0 → `o_done` pulses on the second edge after start.
- With `COUNTER_CTRL_PRESCALE_EN`: `i_div`=2, `i_limit`=2, one-shot → count increments every 3 cycles, and `o_done` asserts 9 cycles after start.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for a WIDTH-bit increment-by-one counter.
// Wraps the count register with start/hold/clear commands, a latched terminal
// limit, and one-shot or auto-reload operation.
//
// Optional feature macro: COUNTER_CTRL_PRESCALE_EN adds i_div and an 8-bit
// prescaler that gates every RUN advance to one edge in (i_div + 1).
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_start    start/restart; latches i_limit and i_mode
//   i_hold     pause counting while high
//   i_clear    synchronous abort to IDLE (highest priority)
//   i_mode     0 = one-shot, 1 = auto-reload
//   i_limit    terminal count
//   i_div      prescale divisor (COUNTER_CTRL_PRESCALE_EN only)
//   o_count    current count
//   o_busy     high in RUN and HOLD
//   o_done     one-cycle pulse on the one-shot terminal
//   o_wrap     one-cycle pulse on an auto-reload wrap
module counter_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_hold,
    input  logic             i_clear,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_limit,
`ifdef COUNTER_CTRL_PRESCALE_EN
    input  logic [7:0]       i_div,
`endif
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wrap
);

    localparam int unsigned PW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q,  mode_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             wrap_q,  wrap_d;
    logic             tick_c;

`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [PW-1:0]    presc_q, presc_d;

    // A tick fires when the prescaler reaches the divisor; i_div = 0 ticks every edge.
    assign tick_c = (presc_q == i_div);
`else
    assign tick_c = 1'b1;
`endif

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
            presc_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
`ifdef COUNTER_CTRL_PRESCALE_EN
            presc_q <= presc_d;
`endif
        end
    end

    // Next-state and registered-output logic; priority clear > start > hold
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        presc_d = presc_q;
`endif

        if (i_clear) begin
            state_d = ST_IDLE;
            count_d = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
            presc_d = '0;
`endif
        end else if (i_start) begin
            state_d = ST_RUN;
            count_d = '0;
            limit_d = i_limit;
            mode_d  = i_mode;
`ifdef COUNTER_CTRL_PRESCALE_EN
            presc_d = '0;
`endif
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (i_hold) begin
                        state_d = ST_HOLD;
                    end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
                        presc_d = tick_c ? '0 : presc_q + PW'(1);
`endif
                        if (tick_c) begin
                            // Counter never passes the limit, so no overflow is possible.
                            if (count_q == limit_q) begin
                                if (mode_q) begin
                                    count_d = '0;
                                    wrap_d  = 1'b1;
                                end else begin
                                    state_d = ST_DONE;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                count_d = count_q + WIDTH'(1);
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    // Exit edge is non-counting; advance resumes on the next edge.
                    if (!i_hold) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    end

    assign o_count = count_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl.
module tb_counter_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_start;
    logic             i_hold;
    logic             i_clear;
    logic             i_mode;
    logic [WIDTH-1:0] i_limit;
`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [7:0]       i_div;
`endif
    logic [WIDTH-1:0] o_count;
    logic             o_busy;
    logic             o_done;
    logic             o_wrap;

    int n_checks = 0;
    int n_errors = 0;

    counter_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_hold  (i_hold),
        .i_clear (i_clear),
        .i_mode  (i_mode),
        .i_limit (i_limit),
`ifdef COUNTER_CTRL_PRESCALE_EN
        .i_div   (i_div),
`endif
        .o_count (o_count),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_wrap  (o_wrap)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int cnt, input bit busy,
                             input bit done, input bit wrap);
        check({tag, ".count"}, 32'(o_count), 32'(cnt));
        check({tag, ".busy"},  32'(o_busy),  32'(busy));
        check({tag, ".done"},  32'(o_done),  32'(done));
        check({tag, ".wrap"},  32'(o_wrap),  32'(wrap));
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_hold  = 1'b0;
        i_clear = 1'b0;
        i_mode  = 1'b0;
        i_limit = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        i_div   = 8'd0;
`endif

        // Reset state, then 10 idle cycles
        #23;
        check_out("reset", 0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("idle", 0, 1'b0, 1'b0, 1'b0);
        end

        // One-shot, limit 5
        i_start = 1'b1; i_limit = 16'd5; i_mode = 1'b0;
        tick();
        i_start = 1'b0;
        check_out("os_start", 0, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            tick();
            check_out("os_run", n, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_out("os_done", 5, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("os_after", 5, 1'b0, 1'b0, 1'b0);

        // Auto-reload, limit 3: period 4, wrap when 0 follows 3
        i_start = 1'b1; i_limit = 16'd3; i_mode = 1'b1;
        tick();
        i_start = 1'b0;
        check_out("ar_start", 0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_out("ar_run", i % 4, 1'b1, 1'b0, (i % 4) == 0);
        end

        // Clear wins over simultaneous start
        i_clear = 1'b1; i_start = 1'b1; i_limit = 16'd9; i_mode = 1'b0;
        tick();
        i_clear = 1'b0; i_start = 1'b0;
        check_out("clr_start", 0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("clr_idle", 0, 1'b0, 1'b0, 1'b0);

        // Hold for 4 cycles at count 2: completion delayed by 5 edges
        i_start = 1'b1; i_limit = 16'd5; i_mode = 1'b0;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        check_out("hold_pre", 2, 1'b1, 1'b0, 1'b0);
        i_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("hold_frozen", 2, 1'b1, 1'b0, 1'b0);
        end
        i_hold = 1'b0;
        tick();
        check_out("hold_exit", 2, 1'b1, 1'b0, 1'b0);
        for (int n = 3; n <= 5; n++) begin
            tick();
            check_out("hold_resume", n, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_out("hold_done", 5, 1'b0, 1'b1, 1'b0);

        // Restart mid-run aborts without pulse and relatches limit/mode
        i_start = 1'b1; i_limit = 16'd10; i_mode = 1'b0;
        tick();
        i_start = 1'b0;
        tick(); tick(); tick();
        check_out("rs_mid", 3, 1'b1, 1'b0, 1'b0);
        i_start = 1'b1; i_limit = 16'd1; i_mode = 1'b1;
        tick();
        i_start = 1'b0;
        check_out("rs_restart", 0, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("rs_one", 1, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("rs_wrap", 0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset at count 7
        i_start = 1'b1; i_limit = 16'd20; i_mode = 1'b0;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_out("ar_pre", 7, 1'b1, 1'b0, 1'b0);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 1'b0, 1'b0, 1'b0);
        #1;
        i_rst_n = 1'b1;
        tick();
        check_out("rst_release", 0, 1'b0, 1'b0, 1'b0);

        // Limit 0 one-shot: done on the second edge after start
        i_start = 1'b1; i_limit = 16'd0; i_mode = 1'b0;
        tick();
        i_start = 1'b0;
        check_out("l0_os_start", 0, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("l0_os_done", 0, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("l0_os_after", 0, 1'b0, 1'b0, 1'b0);

        // Limit 0 auto-reload: wrap every cycle
        i_start = 1'b1; i_limit = 16'd0; i_mode = 1'b1;
        tick();
        i_start = 1'b0;
        check_out("l0_ar_start", 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("l0_ar_wrap", 0, 1'b1, 1'b0, 1'b1);
        end

`ifdef COUNTER_CTRL_PRESCALE_EN
        // Prescale div 2, limit 2, one-shot: advance every 3 edges, done 9 edges after start
        i_start = 1'b1; i_limit = 16'd2; i_mode = 1'b0; i_div = 8'd2;
        tick();
        i_start = 1'b0;
        check_out("ps_start", 0, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e < 9; e++) begin
            tick();
            check_out("ps_run", e / 3, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_out("ps_done", 2, 1'b0, 1'b1, 1'b0);
        i_div = 8'd0;
`endif

        // Clear from any state returns to IDLE
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check_out("final_clear", 0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
